// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_pkg                                                                    |
// | Shared state encoding and default sizing for the round-robin lock arbiter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package arb_pkg;

    localparam int c_N_DEFAULT        = 16;
    localparam int c_MAX_HOLD_DEFAULT = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick                                                                    |
// | Wrap-around priority pick: first set request at or above i_ptr.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = c_N_DEFAULT
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_id,
    output logic                 o_valid
);

    localparam int IDW = $clog2(N);
    localparam logic [2*N-1:0] c_ONE = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_mask;
    logic [2*N-1:0] w_masked;
    logic [2*N-1:0] w_lowest;
    logic [N-1:0]   w_onehot;

    // Upper copy holds every request, so a request below i_ptr is still
    // found there after masking: that is the wrap-around.
    assign w_dbl    = {i_req, i_req};
    assign w_mask   = ~((c_ONE << i_ptr) - c_ONE);
    assign w_masked = w_dbl & w_mask;
    assign w_lowest = w_masked & ~(w_masked - c_ONE);
    assign w_onehot = w_lowest[N-1:0] | w_lowest[2*N-1:N];

    assign o_grant = w_onehot;
    assign o_valid = |i_req;

    always_comb begin
        o_grant_id = '0;
        for (int i = 0; i < N; i++) begin
            if (w_onehot[i]) begin
                o_grant_id = IDW'(i);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter_lock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter_lock                                                            |
// | Round-robin arbiter with locked tenancy; ARB_TIMEOUT_EN adds a watchdog.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter_lock
    import arb_pkg::*;
#(
    parameter int N        = c_N_DEFAULT,
    parameter int MAX_HOLD = c_MAX_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);

    arb_state_e     r_state;
    arb_state_e     w_state_next;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   w_grant_next;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] w_grant_id_next;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_next;

    logic [N-1:0]   w_pick_grant;
    logic [IDW-1:0] w_pick_id;
    logic           w_pick_valid;
    logic           w_own_done;
    logic           w_own_req;
    logic           w_force;
    logic           w_release;
    logic           w_arb;

    rr_pick #(
        .N (N)
    ) u_pick (
        .i_req      (req),
        .i_ptr      (r_ptr),
        .o_grant    (w_pick_grant),
        .o_grant_id (w_pick_id),
        .o_valid    (w_pick_valid)
    );

    assign w_own_done = |(r_grant & done);
    assign w_own_req  = |(r_grant & req);
    assign w_release  = (r_state == BUSY) && (w_own_done || !w_own_req || w_force);
    assign w_arb      = (r_state == IDLE) || w_release;

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_grant_id_next = r_grant_id;
        w_ptr_next      = r_ptr;
        if (w_arb) begin
            if (w_pick_valid) begin
                w_state_next    = BUSY;
                w_grant_next    = w_pick_grant;
                w_grant_id_next = w_pick_id;
                w_ptr_next      = (w_pick_id == IDW'(N - 1)) ? '0 : w_pick_id + IDW'(1);
            end else begin
                w_state_next    = IDLE;
                w_grant_next    = '0;
                w_grant_id_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_grant_id <= w_grant_id_next;
            r_ptr      <= w_ptr_next;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = |r_grant;

`ifdef ARB_TIMEOUT_EN
    localparam int c_hold_w = $clog2(MAX_HOLD + 1);

    // r_hold counts completed cycles of the current tenancy; r_timeout marks
    // the MAX_HOLD-th cycle, in which the watchdog ends the tenancy.
    logic [c_hold_w-1:0] r_hold;
    logic [c_hold_w-1:0] w_hold_next;
    logic                r_timeout;
    logic                w_timeout_next;

    always_comb begin
        w_hold_next    = r_hold;
        w_timeout_next = 1'b0;
        if (w_arb) begin
            w_hold_next    = '0;
            w_timeout_next = w_pick_valid && (MAX_HOLD == 1);
        end else if (r_state == BUSY) begin
            w_hold_next    = r_hold + c_hold_w'(1);
            w_timeout_next = (r_hold + c_hold_w'(1)) == c_hold_w'(MAX_HOLD - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= w_hold_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign w_force = r_timeout;
    assign timeout = r_timeout;
`else
    logic w_unused_hold;

    assign w_unused_hold = (MAX_HOLD > 0);
    assign w_force       = 1'b0;
    assign timeout       = 1'b0;
`endif

endmodule : rr_arbiter_lock
`default_nettype wire

// File: tb/tb_rr_arbiter_lock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rr_arbiter_lock                                                         |
// | Scoreboard bench: driver pushes model expectations, monitor pops/compares. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rr_arbiter_lock;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic [N-1:0] req  = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   id;
        logic         busy;
        logic         tmo;
    } exp_t;

    exp_t q[$];
    int   m_owner  = -1;
    int   m_ptr    = 0;
    int   m_cycles = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    rr_arbiter_lock #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    // Reference model: owner index, rotating priority start and tenancy length.
    task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        exp_t e;
        bit   rel;
        bit   found;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        if (r) begin
            m_owner  = -1;
            m_ptr    = 0;
            m_cycles = 0;
        end else begin
            rel = 1'b0;
            if (m_owner >= 0)
                rel = dn[m_owner] || !rq[m_owner] || (TMO && m_cycles == MAX_HOLD);
            if (m_owner < 0 || rel) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && rq[(m_ptr + k) % N]) begin
                        found   = 1'b1;
                        m_owner = (m_ptr + k) % N;
                    end
                end
                if (found) begin
                    m_ptr    = (m_owner + 1) % N;
                    m_cycles = 1;
                end else begin
                    m_owner  = -1;
                    m_cycles = 0;
                end
            end else begin
                m_cycles++;
            end
        end
        e.grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e.busy  = (m_owner >= 0);
        e.tmo   = TMO && (m_owner >= 0) && (m_cycles == MAX_HOLD);
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant",    32'(grant),    32'(e.grant));
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("busy",     32'(busy),     32'(e.busy));
                chk("timeout",  32'(timeout),  32'(e.tmo));
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] rq;
        logic [N-1:0] dn;
        logic         r;

        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0000, 4'b0000);
        // Fair rotation under full load
        drive(1'b0, 4'b1010, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0010);
        drive(1'b0, 4'b1111, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0100);
        drive(1'b0, 4'b1111, 4'b0000);
        drive(1'b0, 4'b1111, 4'b1000);
        drive(1'b0, 4'b1111, 4'b0000);
        // Non-owner done ignored, then request drop empties the arbiter
        drive(1'b0, 4'b0100, 4'b0001);
        drive(1'b0, 4'b0100, 4'b1001);
        drive(1'b0, 4'b0100, 4'b1001);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b1111);
        // Sole requester re-granted after its own done
        drive(1'b0, 4'b1000, 4'b0000);
        drive(1'b0, 4'b1000, 4'b1000);
        drive(1'b0, 4'b1000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        // Long tenancy: watchdog hand-over or indefinite hold
        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0001, 4'b0000);
        for (int i = 0; i < 100; i++) drive(1'b0, 4'b0011, 4'b0000);
        // Reset in the middle of a tenancy
        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0100, 4'b0000);
        drive(1'b0, 4'b0100, 4'b0000);
        drive(1'b1, 4'b0100, 4'b0000);
        drive(1'b0, 4'b0101, 4'b0000);
        drive(1'b0, 4'b0101, 4'b0000);

        rq = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
                dn[b] = ($urandom_range(0, 5) == 0);
            end
            r = ($urandom_range(0, 149) == 0);
            drive(r, rq, dn);
        end
        drive(1'b0, 4'b0000, 4'b0000);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rr_arbiter_lock
`default_nettype wire

// File: doc/rr_arbiter_lock.md
RR_ARBITER_LOCK -- requirements
Module: rr_arbiter_lock

Interface
REQ-001 SHALL have parameter N, default 16, number of requesters (legal 2..32).
REQ-002 SHALL have parameter MAX_HOLD, default 64, tenancy limit in cycles (used only with ARB_TIMEOUT_EN).
REQ-003 SHALL derive localparam IDW = $clog2(N), width of grant_id.
REQ-004 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have req  input  N  per-requester request level.
REQ-007 SHALL have done  input  N  per-requester end-of-tenancy pulse; only the owner's bit is honoured.
REQ-008 SHALL have grant  output  N  registered one-hot (or zero) grant.
REQ-009 SHALL have grant_id  output  IDW  binary index of the owner, 0 when grant is zero.
REQ-010 SHALL have busy  output  1  high while any grant bit is high.
REQ-011 SHALL have timeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL implement two states: IDLE (grant zero) and BUSY (exactly one grant bit high).
REQ-013 SHALL select the winner in IDLE as the first asserted req bit at or above pointer ptr, wrapping from N-1 to 0.
REQ-014 SHALL register the grant so it appears the cycle after the winning req is sampled, with a one-cycle request-to-grant latency.
REQ-015 SHALL set ptr to (winner+1) mod N on every new grant, so the last winner has lowest priority.
REQ-016 SHALL hold the grant unchanged in BUSY regardless of other req bits.
REQ-017 SHALL release the tenancy in a cycle where done[owner]=1 or req[owner]=0.
REQ-018 SHALL, in a release cycle, re-arbitrate over req (updated ptr) so the next grant appears the following cycle with no idle gap; with no requests, grant goes to zero and the state returns to IDLE.
REQ-019 SHALL let the owner win again at a release only if it is the sole requester.
REQ-020 SHALL ignore done bits of non-owners, and done in IDLE.
REQ-021 SHALL ignore the done bit of a requester winning in the same cycle; the tenancy lasts at least one cycle.
REQ-022 SHALL keep grant_id and busy consistent with grant in every cycle.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set grant=0, grant_id=0, busy=0, timeout=0, ptr=0, state=IDLE, hold counter=0.
REQ-024 SHALL allow reset mid-tenancy to drop the grant the cycle after rst is sampled; the first post-reset arbitration starts from index 0.

Configuration
REQ-025 SHALL use macro ARB_TIMEOUT_EN to compile the tenancy watchdog in or out.
REQ-026 SHALL, when ARB_TIMEOUT_EN is defined, count BUSY cycles of the current owner and, if no release occurs by the MAX_HOLD-th cycle, force a release (REQ-018 rules) and pulse timeout for that cycle; the counter clears on every new grant.
REQ-027 SHALL, when ARB_TIMEOUT_EN is undefined, omit the counter, tie timeout to 0 and hold tenancies indefinitely.

Structure
REQ-028 SHALL place the state enum (IDLE, BUSY) and the default N/MAX_HOLD constants in shared package arb_pkg.
REQ-029 SHALL factor the combinational wrap-around priority pick (req, ptr -> one-hot winner, valid) into sub-module rr_pick, using the double-width request subtract-and-mask technique.

Verification (N=4, MAX_HOLD=8)
REQ-030 SHALL cover: after reset, req=4'b1010 -> grant=4'b0010 the next cycle, grant_id=1, ptr=2.
REQ-031 SHALL cover: owner 1 holds, req=4'b1111 throughout, done[1] pulse -> grant=4'b0100 the next cycle with no zero cycle, then 4'b1000, then 4'b0001 on successive releases (fair rotation).
REQ-032 SHALL cover: owner 2 active, done=4'b1001 (non-owners) -> grant stays 4'b0100; req[2] drops -> grant=4'b0000 and busy=0 next cycle when no other req.
REQ-033 SHALL cover: sole requester 3 releases via done while still requesting -> grant=4'b1000 re-issued the next cycle.
REQ-034 SHALL cover, with ARB_TIMEOUT_EN: owner 0 holds with req=4'b0011 and no done -> on the 8th BUSY cycle timeout=1, next cycle grant=4'b0010; without the macro grant stays 4'b0001 for 100 cycles and timeout stays 0.
REQ-035 SHALL cover: rst asserted during a tenancy of owner 2 -> grant=0 the next cycle; after release req=4'b0101 -> grant=4'b0001.
